omsp_dmem_arbiter: RTL and testbench

Three-way arbiter and address translator that shares the single-port data memory (DMEM) between the debug interface, the execution unit and the frontend. It sits in the memory backbone in front of the DMEM macro. It grants one access per cycle with fixed priority plus frontend anti-starvation, and supports a debug burst lock. It converts 16-bit byte addresses to DMEM word offsets by base subtraction and tracks which requester owns each returning read.

---
 rtl/omsp_dmem_arbiter_pkg.sv | 24 ++
 rtl/omsp_dmem_arbiter_if.sv | 15 +
 rtl/omsp_dmem_arbiter_xlat.sv | 21 ++
 rtl/omsp_dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_omsp_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/omsp_dmem_arbiter_pkg.sv
// Shared types for the DMEM arbiter: requester identity, arbiter state and
// the read-return record carried from the grant cycle to the data cycle.
package omsp_dmem_pkg;

  typedef enum logic [1:0] {
    OWN_DBG = 2'd0,
    OWN_EU  = 2'd1,
    OWN_FE  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  typedef struct packed {
    owner_e owner;
    logic   valid;
    logic   oor;
  } rret_t;

  localparam rret_t RRET_IDLE = '{owner: OWN_DBG, valid: 1'b0, oor: 1'b0};

endpackage

// File: rtl/omsp_dmem_arbiter_if.sv
// One requester port of the DMEM arbiter: request/address/data out from the
// requester, grant/read data/error back from the arbiter.
interface omsp_dmem_arbiter_if;
  logic        req;
  logic [15:0] addr;
  logic [1:0]  wen;
  logic [15:0] din;
  logic        gnt;
  logic [15:0] dout;
  logic        rvalid;
  logic        err;

  modport master (output req, addr, wen, din, input gnt, dout, rvalid, err);
  modport slave  (input req, addr, wen, din, output gnt, dout, rvalid, err);
endinterface

// File: rtl/omsp_dmem_arbiter_xlat.sv
// Byte address to DMEM word offset translation with range check.
module omsp_dmem_xlat #(
  parameter logic [15:0] DMEM_BASE = 16'h0200,
  parameter int          DMEM_SIZE = 512,
  parameter int          AW        = $clog2(DMEM_SIZE / 2)
) (
  input  logic [15:0]   addr_i,
  output logic          in_range_o,
  output logic [AW-1:0] word_addr_o
);

  localparam logic [16:0] SIZE_B = 17'(DMEM_SIZE);

  logic [15:0] off_s;

  // Offset wraps modulo 2^16, so addresses below the base need the explicit compare.
  assign off_s       = addr_i - DMEM_BASE;
  assign in_range_o  = (addr_i >= DMEM_BASE) && ({1'b0, off_s} < SIZE_B);
  assign word_addr_o = off_s[AW:1];

endmodule

// File: rtl/omsp_dmem_arbiter.sv
// Three-way DMEM arbiter: dbg > (starved fe) > eu > fe, with a debug burst
// lock, address translation and one-cycle read return routing.
module omsp_dmem_arbiter
  import omsp_dmem_pkg::*;
#(
  parameter logic [15:0] DMEM_BASE  = 16'h0200,
  parameter int          DMEM_SIZE  = 512,
  parameter int          AW         = $clog2(DMEM_SIZE / 2),
  parameter int          STARVE_MAX = 4
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                dbg_lock,
  omsp_dmem_arbiter_if.slave  dbg,
  omsp_dmem_arbiter_if.slave  eu,
  omsp_dmem_arbiter_if.slave  fe,
  output logic                dmem_cen,
  output logic [1:0]          dmem_wen,
  output logic [AW-1:0]       dmem_addr,
  output logic [15:0]         dmem_din,
  input  logic [15:0]         dmem_dout
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] fe_starve_q, fe_starve_d;
  rret_t         rret_q, rret_d;

  owner_e        sel_own;
  logic          any_gnt;
  logic          gnt_dbg, gnt_eu, gnt_fe;
  logic [15:0]   sel_addr, sel_din;
  logic [1:0]    sel_wen;
  logic          in_range;
  logic [AW-1:0] word_addr;
  logic          rv_any;
  logic [15:0]   rdata;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= ST_ARB;
      fe_starve_q <= '0;
      rret_q      <= RRET_IDLE;
    end else begin
      state_q     <= state_d;
      fe_starve_q <= fe_starve_d;
      rret_q      <= rret_d;
    end
  end

  // While locked only dbg may win; dropping dbg_lock re-arbitrates in the same cycle.
  always_comb begin
    sel_own = OWN_DBG;
    any_gnt = 1'b0;
    state_d = state_q;
    if (puc_rst) begin
      state_d = ST_ARB;
    end else if ((state_q == ST_LOCK) && dbg_lock) begin
      any_gnt = dbg.req;
      state_d = ST_LOCK;
    end else begin
      if (dbg.req) begin
        any_gnt = 1'b1;
        sel_own = OWN_DBG;
      end else if (fe.req && (fe_starve_q == STARVE_TOP)) begin
        any_gnt = 1'b1;
        sel_own = OWN_FE;
      end else if (eu.req) begin
        any_gnt = 1'b1;
        sel_own = OWN_EU;
      end else if (fe.req) begin
        any_gnt = 1'b1;
        sel_own = OWN_FE;
      end else begin
        any_gnt = 1'b0;
      end
      state_d = (any_gnt && (sel_own == OWN_DBG) && dbg_lock) ? ST_LOCK : ST_ARB;
    end
  end

  assign gnt_dbg = any_gnt && (sel_own == OWN_DBG);
  assign gnt_eu  = any_gnt && (sel_own == OWN_EU);
  assign gnt_fe  = any_gnt && (sel_own == OWN_FE);

  always_comb begin
    fe_starve_d = '0;
    if (fe.req && !gnt_fe) begin
      fe_starve_d = (fe_starve_q == STARVE_TOP) ? fe_starve_q : fe_starve_q + SW'(1);
    end else begin
      fe_starve_d = '0;
    end
  end

  always_comb begin
    sel_addr = 16'h0000;
    sel_wen  = 2'b00;
    sel_din  = 16'h0000;
    case (sel_own)
      OWN_DBG: begin sel_addr = dbg.addr; sel_wen = dbg.wen; sel_din = dbg.din; end
      OWN_EU:  begin sel_addr = eu.addr;  sel_wen = eu.wen;  sel_din = eu.din;  end
      OWN_FE:  begin sel_addr = fe.addr;  sel_wen = fe.wen;  sel_din = fe.din;  end
      default: begin sel_addr = 16'h0000; sel_wen = 2'b00; sel_din = 16'h0000; end
    endcase
  end

  omsp_dmem_xlat #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE),
    .AW        (AW)
  ) u_xlat (
    .addr_i      (sel_addr),
    .in_range_o  (in_range),
    .word_addr_o (word_addr)
  );

  // Out-of-range grants leave the macro idle.
  always_comb begin
    dmem_cen  = 1'b1;
    dmem_wen  = 2'b11;
    dmem_addr = '0;
    dmem_din  = 16'h0000;
    if (any_gnt && in_range) begin
      dmem_cen  = 1'b0;
      dmem_wen  = ~sel_wen;
      dmem_addr = word_addr;
      dmem_din  = sel_din;
    end else begin
      dmem_cen  = 1'b1;
    end
  end

  assign rret_d = '{owner: sel_own, valid: any_gnt && (sel_wen == 2'b00), oor: !in_range};

  assign rv_any = rret_q.valid && !puc_rst;
  assign rdata  = rret_q.oor ? 16'h0000 : dmem_dout;

  assign dbg.gnt    = gnt_dbg;
  assign eu.gnt     = gnt_eu;
  assign fe.gnt     = gnt_fe;
  assign dbg.err    = gnt_dbg && !in_range;
  assign eu.err     = gnt_eu && !in_range;
  assign fe.err     = gnt_fe && !in_range;
  assign dbg.rvalid = rv_any && (rret_q.owner == OWN_DBG);
  assign eu.rvalid  = rv_any && (rret_q.owner == OWN_EU);
  assign fe.rvalid  = rv_any && (rret_q.owner == OWN_FE);
  assign dbg.dout   = (rv_any && (rret_q.owner == OWN_DBG)) ? rdata : 16'h0000;
  assign eu.dout    = (rv_any && (rret_q.owner == OWN_EU))  ? rdata : 16'h0000;
  assign fe.dout    = (rv_any && (rret_q.owner == OWN_FE))  ? rdata : 16'h0000;

endmodule

// File: tb/tb_omsp_dmem_arbiter.sv
// Scoreboard bench: the driver queues expected grants and read returns, a
// negedge monitor pops and compares them whenever the DUT shows gnt/rvalid.
module tb_omsp_dmem_arbiter;
  import omsp_dmem_pkg::*;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        dbg_lock;
  logic        dmem_cen;
  logic [1:0]  dmem_wen;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;

  omsp_dmem_arbiter_if dbg_if ();
  omsp_dmem_arbiter_if eu_if ();
  omsp_dmem_arbiter_if fe_if ();

  omsp_dmem_arbiter dut (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .dbg_lock  (dbg_lock),
    .dbg       (dbg_if),
    .eu        (eu_if),
    .fe        (fe_if),
    .dmem_cen  (dmem_cen),
    .dmem_wen  (dmem_wen),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout)
  );

  typedef struct {
    logic [1:0]  own;
    logic        err;
    logic        cen;
    logic [7:0]  addr;
    logic [1:0]  wen;
    logic [15:0] din;
  } gexp_t;

  typedef struct {
    logic [1:0]  own;
    logic [15:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  always #5 mclk = ~mclk;

  // Memory stand-in: read data is a tag of the word address accessed last cycle.
  always @(posedge mclk) dmem_dout <= dmem_cen ? 16'hDEAD : (16'hC000 | {8'h00, dmem_addr});

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge mclk) begin
    logic [2:0]  g, rv, ev;
    logic [1:0]  own;
    logic [15:0] dv;
    gexp_t       ge;
    rexp_t       re;
    g  = {fe_if.gnt, eu_if.gnt, dbg_if.gnt};
    rv = {fe_if.rvalid, eu_if.rvalid, dbg_if.rvalid};
    ev = {fe_if.err, eu_if.err, dbg_if.err};
    chk("gnt_onehot", 32'($countones(g) <= 1), 32'd1);
    if (g != 3'b000) begin
      own = g[0] ? 2'd0 : (g[1] ? 2'd1 : 2'd2);
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(g), 32'd0);
      end else begin
        ge = gq.pop_front();
        chk("gnt_owner", 32'(own), 32'(ge.own));
        chk("gnt_err", 32'(ev), ge.err ? 32'(3'b001 << ge.own) : 32'd0);
        chk("gnt_cen", 32'(dmem_cen), 32'(ge.cen));
        chk("gnt_addr", 32'(dmem_addr), 32'(ge.addr));
        chk("gnt_wen", 32'(dmem_wen), 32'(ge.wen));
        chk("gnt_din", 32'(dmem_din), 32'(ge.din));
      end
    end else begin
      chk("idle_cen", 32'(dmem_cen), 32'd1);
      chk("idle_err", 32'(ev), 32'd0);
    end
    if (rv != 3'b000) begin
      own = rv[0] ? 2'd0 : (rv[1] ? 2'd1 : 2'd2);
      dv  = rv[0] ? dbg_if.dout : (rv[1] ? eu_if.dout : fe_if.dout);
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", 32'(rv), 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rd_owner", 32'(own), 32'(re.own));
        chk("rd_data", 32'(dv), 32'(re.data));
      end
    end else begin
      chk("idle_dout", 32'(dbg_if.dout | eu_if.dout | fe_if.dout), 32'd0);
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic eg(input logic [1:0] own, input logic err, input logic cen,
                    input logic [7:0] a, input logic [1:0] w, input logic [15:0] d);
    gexp_t e;
    e = '{own: own, err: err, cen: cen, addr: a, wen: w, din: d};
    gq.push_back(e);
  endtask

  task automatic er(input logic [1:0] own, input logic [15:0] d);
    rexp_t e;
    e = '{own: own, data: d};
    rq.push_back(e);
  endtask

  task automatic req(input logic [1:0] who, input logic r, input logic [15:0] a,
                     input logic [1:0] w, input logic [15:0] d);
    case (who)
      2'd0:    begin dbg_if.req = r; dbg_if.addr = a; dbg_if.wen = w; dbg_if.din = d; end
      2'd1:    begin eu_if.req = r;  eu_if.addr = a;  eu_if.wen = w;  eu_if.din = d;  end
      default: begin fe_if.req = r;  fe_if.addr = a;  fe_if.wen = w;  fe_if.din = d;  end
    endcase
  endtask

  task automatic idle_all();
    req(2'd0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    req(2'd1, 1'b0, 16'h0000, 2'b00, 16'h0000);
    req(2'd2, 1'b0, 16'h0000, 2'b00, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    puc_rst  = 1'b1;
    dbg_lock = 1'b0;
    idle_all();
    // Requests during reset must not be granted.
    req(2'd0, 1'b1, 16'h0200, 2'b00, 16'h0000);
    req(2'd1, 1'b1, 16'h0202, 2'b00, 16'h0000);
    tick();
    tick();
    @(negedge mclk);
    chk("rst_gnt", 32'({fe_if.gnt, eu_if.gnt, dbg_if.gnt}), 32'd0);
    chk("rst_rvalid", 32'({fe_if.rvalid, eu_if.rvalid, dbg_if.rvalid}), 32'd0);
    chk("rst_cen", 32'(dmem_cen), 32'd1);
    chk("rst_wen", 32'(dmem_wen), 32'd3);
    chk("rst_addr", 32'(dmem_addr), 32'd0);
    chk("rst_din", 32'(dmem_din), 32'd0);
    tick();
    puc_rst = 1'b0;
    idle_all();
    tick();

    // Single eu read.
    req(2'd1, 1'b1, 16'h0204, 2'b00, 16'h0000);
    eg(2'd1, 1'b0, 1'b0, 8'd2, 2'b11, 16'h0000);
    er(2'd1, 16'hC002);
    tick();
    idle_all();
    tick();

    // Three-way contention, then dbg drops.
    req(2'd0, 1'b1, 16'h0210, 2'b00, 16'h0000);
    req(2'd1, 1'b1, 16'h0220, 2'b00, 16'h0000);
    req(2'd2, 1'b1, 16'h0230, 2'b00, 16'h0000);
    eg(2'd0, 1'b0, 1'b0, 8'd8, 2'b11, 16'h0000);
    er(2'd0, 16'hC008);
    tick();
    req(2'd0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    eg(2'd1, 1'b0, 1'b0, 8'd16, 2'b11, 16'h0000);
    er(2'd1, 16'hC010);
    tick();
    idle_all();
    tick();

    // fe anti-starvation: every fifth cycle goes to fe.
    req(2'd1, 1'b1, 16'h0200, 2'b00, 16'h0000);
    req(2'd2, 1'b1, 16'h0202, 2'b00, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) begin
        eg(2'd2, 1'b0, 1'b0, 8'd1, 2'b11, 16'h0000);
        er(2'd2, 16'hC001);
      end else begin
        eg(2'd1, 1'b0, 1'b0, 8'd0, 2'b11, 16'h0000);
        er(2'd1, 16'hC000);
      end
      tick();
    end
    idle_all();
    tick();

    // Debug lock blocks eu until dbg_lock drops.
    dbg_lock = 1'b1;
    req(2'd0, 1'b1, 16'h0200, 2'b00, 16'h0000);
    req(2'd1, 1'b1, 16'h0240, 2'b00, 16'h0000);
    eg(2'd0, 1'b0, 1'b0, 8'd0, 2'b11, 16'h0000);
    er(2'd0, 16'hC000);
    tick();
    req(2'd0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge mclk);
      chk("lock_hold_eu", 32'(eu_if.gnt), 32'd0);
      tick();
    end
    dbg_lock = 1'b0;
    eg(2'd1, 1'b0, 1'b0, 8'd32, 2'b11, 16'h0000);
    er(2'd1, 16'hC020);
    tick();
    idle_all();
    tick();

    // Address boundaries via fe.
    req(2'd2, 1'b1, 16'h01FE, 2'b00, 16'h0000);
    eg(2'd2, 1'b1, 1'b1, 8'd0, 2'b11, 16'h0000);
    er(2'd2, 16'h0000);
    tick();
    req(2'd2, 1'b1, 16'h0400, 2'b00, 16'h0000);
    eg(2'd2, 1'b1, 1'b1, 8'd0, 2'b11, 16'h0000);
    er(2'd2, 16'h0000);
    tick();
    req(2'd2, 1'b1, 16'h03FE, 2'b00, 16'h0000);
    eg(2'd2, 1'b0, 1'b0, 8'd255, 2'b11, 16'h0000);
    er(2'd2, 16'hC0FF);
    tick();
    req(2'd2, 1'b1, 16'hFFFE, 2'b00, 16'h0000);
    eg(2'd2, 1'b1, 1'b1, 8'd0, 2'b11, 16'h0000);
    er(2'd2, 16'h0000);
    tick();
    idle_all();
    tick();

    // Byte write, then a read whose return is killed by reset.
    req(2'd1, 1'b1, 16'h0200, 2'b01, 16'hA5A5);
    eg(2'd1, 1'b0, 1'b0, 8'd0, 2'b10, 16'hA5A5);
    tick();
    req(2'd1, 1'b1, 16'h0206, 2'b00, 16'h0000);
    eg(2'd1, 1'b0, 1'b0, 8'd3, 2'b11, 16'h0000);
    tick();
    puc_rst = 1'b1;
    idle_all();
    @(negedge mclk);
    chk("rst_drop_rvalid", 32'(eu_if.rvalid), 32'd0);
    chk("rst_drop_dout", 32'(eu_if.dout), 32'd0);
    tick();
    puc_rst = 1'b0;
    tick();
    tick();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
